vi_main_memory: RTL and testbench

VI_MAIN_MEMORY -- requirements
Module: vi_main_memory

---
 rtl/vi_mem_pkg.sv | 20 ++
 rtl/vi_mem_req_fifo.sv | 65 ++++++
 rtl/vi_main_memory.sv | 172 +++++++++++++++++
 tb/tb_vi_main_memory.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vi_mem_pkg.sv
// Shared defaults, line-offset helper and responder state type for vi_main_memory.
package vi_mem_pkg;

  localparam int VI_MEM_ADDR_W = 20;
  localparam int VI_MEM_LINE_W = 128;
  localparam int VI_MEM_WORD_W = 32;
  localparam int VI_MEM_DEPTH  = 65536;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } vi_mem_state_e;

  // number of byte-offset address bits inside a unit of width_bits
  function automatic int vi_mem_off(input int width_bits);
    return $clog2(width_bits / 8);
  endfunction

endpackage

// File: rtl/vi_mem_req_fifo.sv
// In-order read request queue of QDEPTH (power of 2, >= 2) addresses with
// registered empty/full flags.
module vi_mem_req_fifo #(
  parameter int QDEPTH = 4,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic              empty,
  output logic              full
);

  localparam int PW = $clog2(QDEPTH);

  logic [ADDR_W-1:0] slot_r [QDEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW:0]       count_r;
  logic [PW:0]       count_next_s;
  logic              empty_r;
  logic              full_r;

  // occupancy update; push and pop together leave it unchanged
  always_comb begin
    count_next_s = count_r;
    if (push && !pop) begin
      count_next_s = count_r + (PW+1)'(1);
    end else if (!push && pop) begin
      count_next_s = count_r - (PW+1)'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // pointers and flags; pointers wrap naturally modulo QDEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_next_s;
      empty_r <= (count_next_s == (PW+1)'(0));
      full_r  <= (count_next_s == (PW+1)'(QDEPTH));
    end
  end

  // storage slots
  always_ff @(posedge clk) begin
    if (push) slot_r[wr_ptr_r] <= push_addr;
  end

  assign head_addr = slot_r[rd_ptr_r];
  assign empty     = empty_r;
  assign full      = full_r;

endmodule

// File: rtl/vi_main_memory.sv
// Line-read / word-or-byte-write main memory with queued, fixed-latency in-order reads.
// Optional VI_MEM_ERR_CHECK_EN adds mem_err_o and out-of-range handling.
module vi_main_memory
  import vi_mem_pkg::*;
#(
  parameter int    ADDR_W    = VI_MEM_ADDR_W,
  parameter int    LINE_W    = VI_MEM_LINE_W,
  parameter int    WORD_W    = VI_MEM_WORD_W,
  parameter int    DEPTH     = VI_MEM_DEPTH,
  parameter int    LATENCY   = 1,
  parameter int    QDEPTH    = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              mem_read_i,
  input  logic [ADDR_W-1:0] mem_read_addr_i,
  input  logic              mem_write_enable_i,
  input  logic              mem_write_byte_i,
  input  logic [ADDR_W-1:0] mem_write_addr_i,
  input  logic [WORD_W-1:0] mem_write_data_i,
  output logic              mem_data_ready_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_busy_o
`ifdef VI_MEM_ERR_CHECK_EN
  ,
  output logic              mem_err_o
`endif
);

  localparam int OFF   = vi_mem_off(LINE_W);
  localparam int WOFF  = vi_mem_off(WORD_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [LINE_W-1:0]   mem_r [DEPTH];
  vi_mem_state_e       state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [ADDR_W-1:0]   cur_addr_r, head_addr_s, sample_addr_s;
  logic                fifo_empty_s, fifo_full_s, push_s, pop_s;
  logic [IDX_W-1:0]    rd_idx_s, wr_idx_s;
  logic [LINE_W-1:0]   rd_line_s;
  logic                wr_en_s;
  logic [OFF-1:0]      byte_sel_s;
  logic [OFF-WOFF-1:0] word_sel_s;
  logic                ready_r;
  logic [LINE_W-1:0]   data_r;
  logic [ADDR_W-1:0]   addr_r;
`ifdef VI_MEM_ERR_CHECK_EN
  logic                err_r;
`endif

  function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(32'(addr[ADDR_W-1:OFF]) % 32'(DEPTH));
  endfunction

`ifdef VI_MEM_ERR_CHECK_EN
  function automatic logic line_oor(input logic [ADDR_W-1:0] addr);
    return (32'(addr[ADDR_W-1:OFF]) >= 32'(DEPTH));
  endfunction
`endif

  vi_mem_req_fifo #(
    .QDEPTH (QDEPTH),
    .ADDR_W (ADDR_W)
  ) u_req_fifo (
    .clk       (clk_i),
    .rst_n     (rsn_i),
    .push      (push_s),
    .push_addr (mem_read_addr_i),
    .pop       (pop_s),
    .head_addr (head_addr_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // acceptance, line selection and write gating; a popping cycle samples the head directly
  always_comb begin
    push_s        = mem_read_i & ~fifo_full_s;
    sample_addr_s = pop_s ? head_addr_s : cur_addr_r;
    rd_idx_s      = line_idx(sample_addr_s);
    wr_idx_s      = line_idx(mem_write_addr_i);
    byte_sel_s    = mem_write_addr_i[OFF-1:0];
    word_sel_s    = mem_write_addr_i[OFF-1:WOFF];
`ifdef VI_MEM_ERR_CHECK_EN
    rd_line_s     = line_oor(sample_addr_s) ? '0 : mem_r[rd_idx_s];
    wr_en_s       = mem_write_enable_i & ~line_oor(mem_write_addr_i);
`else
    rd_line_s     = mem_r[rd_idx_s];
    wr_en_s       = mem_write_enable_i;
`endif
  end

  // responder next state; LATENCY=1 bypasses WAIT so responses can run back to back
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          cnt_next_s   = CNT_W'(LATENCY - 1);
          state_next_s = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_next_s = cnt_r - CNT_W'(1);
        if (cnt_next_s == CNT_W'(0)) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = CNT_W'(0);
      end
    endcase
  end

  // responder state and registered response outputs
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      cur_addr_r <= '0;
      ready_r    <= 1'b0;
      data_r     <= '0;
      addr_r     <= '0;
`ifdef VI_MEM_ERR_CHECK_EN
      err_r      <= 1'b0;
`endif
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s == ST_RESP);
      if (pop_s) cur_addr_r <= head_addr_s;
      if (state_next_s == ST_RESP) begin
        data_r <= rd_line_s;
        addr_r <= sample_addr_s;
      end
`ifdef VI_MEM_ERR_CHECK_EN
      err_r <= ((state_next_s == ST_RESP) && line_oor(sample_addr_s)) ||
               (mem_write_enable_i && line_oor(mem_write_addr_i));
`endif
    end
  end

  // array update; contents intentionally survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      if (mem_write_byte_i) begin
        mem_r[wr_idx_s][int'(byte_sel_s)*8 +: 8] <= mem_write_data_i[7:0];
      end else begin
        mem_r[wr_idx_s][int'(word_sel_s)*WORD_W +: WORD_W] <= mem_write_data_i;
      end
    end
  end

  assign mem_data_ready_o = ready_r;
  assign mem_data_o       = data_r;
  assign mem_addr_o       = addr_r;
  assign mem_busy_o       = fifo_full_s;
`ifdef VI_MEM_ERR_CHECK_EN
  assign mem_err_o        = err_r;
`endif

endmodule

// File: tb/tb_vi_main_memory.sv
// Directed self-checking bench for vi_main_memory (LATENCY=1 and LATENCY=4 instances,
// plus a DEPTH=256 instance when VI_MEM_ERR_CHECK_EN is defined).
`timescale 1ns/1ps
module tb_vi_main_memory;

  localparam logic [127:0] LINE_100 = {32'h3, 32'h2, 32'h1, 32'h0};
  localparam logic [127:0] LINE_A   = {32'h44444444, 32'h33333333, 32'h22222222, 32'hAB111111};
  localparam logic [127:0] LINE_B   = {32'hDEADBEEF, 32'h33333333, 32'h5A5A5A5A, 32'hAB111111};

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         r1_req, w1_en, w1_byte, o1_rdy, o1_busy;
  logic [19:0]  r1_addr, w1_addr, o1_addr;
  logic [31:0]  w1_data;
  logic [127:0] o1_data;
  logic         r4_req, w4_en, w4_byte, o4_rdy, o4_busy;
  logic [19:0]  r4_addr, w4_addr, o4_addr;
  logic [31:0]  w4_data;
  logic [127:0] o4_data;
`ifdef VI_MEM_ERR_CHECK_EN
  logic         o1_err, o4_err;
  logic         re_req, we_en, we_byte, oe_rdy, oe_busy, oe_err;
  logic [19:0]  re_addr, we_addr, oe_addr;
  logic [31:0]  we_data;
  logic [127:0] oe_data;
  int           err_pulses = 0;
  logic [127:0] qe_data[$];
`endif

  logic [19:0]  q1_addr[$], q4_addr[$];
  logic [127:0] q1_data[$], q4_data[$];
  int           q1_cyc[$], q4_cyc[$];
  logic         busy1_seen = 1'b0;

  vi_main_memory #(.LATENCY(1)) u_dut1 (
    .clk_i(clk), .rsn_i(rst_n), .mem_read_i(r1_req), .mem_read_addr_i(r1_addr),
    .mem_write_enable_i(w1_en), .mem_write_byte_i(w1_byte), .mem_write_addr_i(w1_addr),
    .mem_write_data_i(w1_data), .mem_data_ready_o(o1_rdy), .mem_data_o(o1_data),
    .mem_addr_o(o1_addr), .mem_busy_o(o1_busy)
`ifdef VI_MEM_ERR_CHECK_EN
    , .mem_err_o(o1_err)
`endif
  );

  vi_main_memory #(.LATENCY(4), .QDEPTH(4)) u_dut4 (
    .clk_i(clk), .rsn_i(rst_n), .mem_read_i(r4_req), .mem_read_addr_i(r4_addr),
    .mem_write_enable_i(w4_en), .mem_write_byte_i(w4_byte), .mem_write_addr_i(w4_addr),
    .mem_write_data_i(w4_data), .mem_data_ready_o(o4_rdy), .mem_data_o(o4_data),
    .mem_addr_o(o4_addr), .mem_busy_o(o4_busy)
`ifdef VI_MEM_ERR_CHECK_EN
    , .mem_err_o(o4_err)
`endif
  );

`ifdef VI_MEM_ERR_CHECK_EN
  vi_main_memory #(.LATENCY(1), .DEPTH(256)) u_dute (
    .clk_i(clk), .rsn_i(rst_n), .mem_read_i(re_req), .mem_read_addr_i(re_addr),
    .mem_write_enable_i(we_en), .mem_write_byte_i(we_byte), .mem_write_addr_i(we_addr),
    .mem_write_data_i(we_data), .mem_data_ready_o(oe_rdy), .mem_data_o(oe_data),
    .mem_addr_o(oe_addr), .mem_busy_o(oe_busy), .mem_err_o(oe_err)
  );
`endif

  // response monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (o1_rdy) begin
      q1_addr.push_back(o1_addr); q1_data.push_back(o1_data); q1_cyc.push_back(cyc);
    end
    if (o1_busy) busy1_seen = 1'b1;
    if (o4_rdy) begin
      q4_addr.push_back(o4_addr); q4_data.push_back(o4_data); q4_cyc.push_back(cyc);
    end
`ifdef VI_MEM_ERR_CHECK_EN
    if (oe_err) err_pulses++;
    if (oe_rdy) qe_data.push_back(oe_data);
`endif
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mwrite(input int d, input logic b, input logic [19:0] a, input logic [31:0] v);
    if (d == 1) begin
      w1_en = 1'b1; w1_byte = b; w1_addr = a; w1_data = v;
    end else if (d == 4) begin
      w4_en = 1'b1; w4_byte = b; w4_addr = a; w4_data = v;
    end else begin
`ifdef VI_MEM_ERR_CHECK_EN
      we_en = 1'b1; we_byte = b; we_addr = a; we_data = v;
`endif
    end
    @(posedge clk); #1;
    w1_en = 1'b0; w4_en = 1'b0;
`ifdef VI_MEM_ERR_CHECK_EN
    we_en = 1'b0;
`endif
  endtask

  task automatic mread(input int d, input logic [19:0] a, output int acc);
    if (d == 1) begin
      r1_req = 1'b1; r1_addr = a;
    end else if (d == 4) begin
      r4_req = 1'b1; r4_addr = a;
    end else begin
`ifdef VI_MEM_ERR_CHECK_EN
      re_req = 1'b1; re_addr = a;
`endif
    end
    @(posedge clk); #1;
    acc = cyc;
    r1_req = 1'b0; r4_req = 1'b0;
`ifdef VI_MEM_ERR_CHECK_EN
    re_req = 1'b0;
`endif
  endtask

  task automatic wait_q(input int d, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (((d == 1) ? q1_cyc.size() : q4_cyc.size()) >= n) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, acc0, k, guard;
    logic acc_now;
    int acc4[6];
    logic bz[6];

    rst_n = 1'b0;
    r1_req = 1'b0; r1_addr = '0; w1_en = 1'b0; w1_byte = 1'b0; w1_addr = '0; w1_data = '0;
    r4_req = 1'b0; r4_addr = '0; w4_en = 1'b0; w4_byte = 1'b0; w4_addr = '0; w4_data = '0;
`ifdef VI_MEM_ERR_CHECK_EN
    re_req = 1'b0; re_addr = '0; we_en = 1'b0; we_byte = 1'b0; we_addr = '0; we_data = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready1", 128'(o1_rdy), 128'd0);
    chk("rst_data1", o1_data, 128'd0);
    chk("rst_addr1", 128'(o1_addr), 128'd0);
    chk("rst_busy1", 128'(o1_busy), 128'd0);
    chk("rst_ready4", 128'(o4_rdy), 128'd0);
    chk("rst_busy4", 128'(o4_busy), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single read, LATENCY=1
    for (int i = 0; i < 4; i++) mwrite(1, 1'b0, 20'h01000 + 20'(4*i), 32'(i));
    mread(1, 20'h01000, acc);
    wait_q(1, 1, 10);
    chk("s1_count", 128'(q1_cyc.size()), 128'd1);
    if (q1_cyc.size() >= 1) begin
      chk("s1_latency", 128'(q1_cyc[0] - acc), 128'd1);
      chk("s1_data", q1_data[0], LINE_100);
      chk("s1_addr", 128'(q1_addr[0]), 128'h01000);
    end
    @(negedge clk);
    chk("s1_hold_data", o1_data, LINE_100);
    @(posedge clk); #1;

    // back-to-back reads, LATENCY=1
    q1_addr.delete(); q1_data.delete(); q1_cyc.delete(); busy1_seen = 1'b0;
    r1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r1_addr = 20'h01000 + 20'(16*i);
      @(posedge clk); #1;
      if (i == 0) acc0 = cyc;
    end
    r1_req = 1'b0;
    wait_q(1, 3, 10);
    chk("b2b_count", 128'(q1_cyc.size()), 128'd3);
    if (q1_cyc.size() >= 3) begin
      chk("b2b_first", 128'(q1_cyc[0] - acc0), 128'd1);
      chk("b2b_span", 128'(q1_cyc[2] - q1_cyc[0]), 128'd2);
      for (int i = 0; i < 3; i++) chk("b2b_order", 128'(q1_addr[i]), 128'(20'h01000 + 20'(16*i)));
    end
    chk("b2b_no_busy", 128'(busy1_seen), 128'd0);

    // byte write then read, then read-before-write on the sampling edge
    mwrite(1, 1'b0, 20'h12000, 32'h11111111);
    mwrite(1, 1'b0, 20'h12004, 32'h22222222);
    mwrite(1, 1'b0, 20'h12008, 32'h33333333);
    mwrite(1, 1'b0, 20'h1200C, 32'h44444444);
    mwrite(1, 1'b1, 20'h12003, 32'hFFFFFFAB);
    q1_addr.delete(); q1_data.delete(); q1_cyc.delete();
    r1_req = 1'b1; r1_addr = 20'h12000;
    @(posedge clk); #1;
    r1_req = 1'b0;
    mwrite(1, 1'b0, 20'h1200C, 32'hDEADBEEF);
    wait_q(1, 1, 10);
    chk("rbw_count", 128'(q1_cyc.size()), 128'd1);
    if (q1_cyc.size() >= 1) chk("byte_and_rbw_data", q1_data[0], LINE_A);
    mwrite(1, 1'b0, 20'h12006, 32'h5A5A5A5A);
    q1_data.delete(); q1_cyc.delete(); q1_addr.delete();
    mread(1, 20'h12000, acc);
    wait_q(1, 1, 10);
    chk("after_write_count", 128'(q1_cyc.size()), 128'd1);
    if (q1_cyc.size() >= 1) chk("after_write_data", q1_data[0], LINE_B);

    // LATENCY=4, six requests held against busy
    for (int i = 0; i < 6; i++) mwrite(4, 1'b0, 20'h02000 + 20'(16*i), 32'hA0 + 32'(i));
    q4_addr.delete(); q4_data.delete(); q4_cyc.delete();
    k = 0; guard = 0;
    r4_req = 1'b1;
    while (k < 6 && guard < 100) begin
      r4_addr = 20'h02000 + 20'(16*k);
      acc_now = !o4_busy;
      @(posedge clk); #1;
      if (acc_now) begin
        acc4[k] = cyc; bz[k] = o4_busy; k++;
      end
      guard++;
    end
    r4_req = 1'b0;
    chk("l4_accepted", 128'(k), 128'd6);
    if (k == 6) begin
      chk("l4_busy_after4", 128'(bz[3]), 128'd0);
      chk("l4_busy_after5", 128'(bz[4]), 128'd1);
      chk("l4_acc5_cycle", 128'(acc4[4] - acc4[0]), 128'd4);
      chk("l4_acc6_cycle", 128'(acc4[5] - acc4[0]), 128'd6);
    end
    wait_q(4, 6, 60);
    chk("l4_resp_count", 128'(q4_cyc.size()), 128'd6);
    if (q4_cyc.size() >= 6 && k == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("l4_order", 128'(q4_addr[i]), 128'(20'h02000 + 20'(16*i)));
        chk("l4_data", 128'(q4_data[i][31:0]), 128'(32'hA0 + 32'(i)));
        chk("l4_timing", 128'(q4_cyc[i] - acc4[0]), 128'(4 + 4*i));
      end
    end

    // reset with three reads queued
    q4_addr.delete(); q4_data.delete(); q4_cyc.delete();
    r4_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r4_addr = 20'h02000 + 20'(16*i);
      @(posedge clk); #1;
    end
    r4_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_no_resp", 128'(q4_cyc.size()), 128'd0);
    chk("rst_mid_busy", 128'(o4_busy), 128'd0);
    @(posedge clk); #1;
    mread(4, 20'h02010, acc);
    wait_q(4, 1, 20);
    chk("rst_fresh_count", 128'(q4_cyc.size()), 128'd1);
    if (q4_cyc.size() >= 1) begin
      chk("rst_fresh_data", 128'(q4_data[0][31:0]), 128'h000000A1);
      chk("rst_fresh_latency", 128'(q4_cyc[0] - acc), 128'd4);
    end

`ifdef VI_MEM_ERR_CHECK_EN
    // out-of-range handling with DEPTH=256
    mwrite(2, 1'b0, 20'h00000, 32'h00000011);
    repeat (2) @(posedge clk); #1;
    err_pulses = 0; qe_data.delete();
    mread(2, 20'h01000, acc);
    repeat (4) @(posedge clk); #1;
    chk("err_read_pulses", 128'(err_pulses), 128'd1);
    chk("err_read_count", 128'(qe_data.size()), 128'd1);
    if (qe_data.size() >= 1) chk("err_read_data", qe_data[0], 128'd0);
    err_pulses = 0;
    mwrite(2, 1'b0, 20'h01000, 32'h00000099);
    repeat (3) @(posedge clk); #1;
    chk("err_write_pulses", 128'(err_pulses), 128'd1);
    err_pulses = 0; qe_data.delete();
    mread(2, 20'h00000, acc);
    repeat (4) @(posedge clk); #1;
    chk("err_inrange_pulses", 128'(err_pulses), 128'd0);
    if (qe_data.size() >= 1) chk("err_write_dropped", 128'(qe_data[0][31:0]), 128'h11);
    else chk("err_inrange_count", 128'(qe_data.size()), 128'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
